// File: rtl/minx_bus_pkg.sv
// MINX bus definitions shared by the arbiter and its masters:
// bus status encodings, arbiter state type and a width helper.
package minx_bus_pkg;

   localparam logic [1:0] BUS_COMMAND_IDLE      = 2'd0;
   localparam logic [1:0] BUS_COMMAND_IRQ_READ  = 2'd1;
   localparam logic [1:0] BUS_COMMAND_MEM_WRITE = 2'd2;
   localparam logic [1:0] BUS_COMMAND_MEM_READ  = 2'd3;

   typedef enum logic [1:0] {
      CPU_OWN,
      WAIT_ACK,
      GRANTED,
      HANDOFF
   } arb_state_t;

   // Bits needed to index n items, never less than one.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of requester, CPU and muxed-bus signals around the MINX bus arbiter.
// The arbiter uses the slave view; masters, CPU and memory side use the master view.
interface bus_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 2
);

   logic [NUM_MASTERS-1:0]    req;
   logic [NUM_MASTERS-1:0]    grant;
   logic [NUM_MASTERS-1:0]    yield;
   logic [NUM_MASTERS*24-1:0] m_address;
   logic [NUM_MASTERS*8-1:0]  m_data;
   logic [NUM_MASTERS-1:0]    m_write;
   logic [NUM_MASTERS-1:0]    m_read;
   logic [NUM_MASTERS*2-1:0]  m_bus_status;
   logic [23:0]               cpu_address;
   logic [7:0]                cpu_data;
   logic                      cpu_write;
   logic                      cpu_read;
   logic [1:0]                cpu_bus_status;
   logic                      cpu_bus_ack;
   logic                      cpu_bus_request;
   logic [23:0]               address_out;
   logic [7:0]                data_out;
   logic                      write;
   logic                      read;
   logic [1:0]                bus_status;
   logic                      protocol_error;

   modport slave (
      input  req, m_address, m_data, m_write, m_read, m_bus_status,
      input  cpu_address, cpu_data, cpu_write, cpu_read, cpu_bus_status, cpu_bus_ack,
      output grant, yield, cpu_bus_request,
      output address_out, data_out, write, read, bus_status, protocol_error
   );

   modport master (
      output req, m_address, m_data, m_write, m_read, m_bus_status,
      output cpu_address, cpu_data, cpu_write, cpu_read, cpu_bus_status, cpu_bus_ack,
      input  grant, yield, cpu_bus_request,
      input  address_out, data_out, write, read, bus_status, protocol_error
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after last_owner, wrapping around.
// Produces a one-hot winner and its index; both zero when nothing is requested.
module rr_pick
   import minx_bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   localparam int unsigned IdxW = idx_width(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IdxW-1:0]        last_owner,
   output logic [NUM_MASTERS-1:0] winner,
   output logic [IdxW-1:0]        winner_idx
);

   logic found;

   // Two passes: masters above last_owner first, then the wrapped-around ones.
   always_comb begin
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (!found && req[i] && (i > int'(last_owner))) begin
            winner[i]  = 1'b1;
            winner_idx = IdxW'(i);
            found      = 1'b1;
         end
      end
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (!found && req[i] && (i <= int'(last_owner))) begin
            winner[i]  = 1'b1;
            winner_idx = IdxW'(i);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// MINX bus arbiter: CPU owns the bus by default; secondary masters get it round-robin
// after a bus_request/bus_ack handshake, with a turnaround cycle between owners.
module bus_arbiter
   import minx_bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned MAX_HOLD    = 0
) (
   input logic             clk,
   input logic             reset,
   input logic             clk_ce,
   bus_arbiter_if.slave    bus
);

   localparam int unsigned IdxW  = idx_width(NUM_MASTERS);
   localparam int unsigned HoldW = idx_width(MAX_HOLD + 1);

   arb_state_t             state_q;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [NUM_MASTERS-1:0] yield_q;
   logic [IdxW-1:0]        last_owner_q;
   logic [HoldW-1:0]       hold_cnt_q;
   logic                   cpu_req_q;
   logic                   err_q;

   logic [NUM_MASTERS-1:0] pick;
   logic [IdxW-1:0]        pick_idx;
   logic                   any_req;
   logic                   owner_req;
   logic                   others_req;

   rr_pick #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_rr_pick (
      .req       (bus.req),
      .last_owner(last_owner_q),
      .winner    (pick),
      .winner_idx(pick_idx)
   );

   assign any_req    = |bus.req;
   assign owner_req  = |(bus.req & grant_q);
   assign others_req = |(bus.req & ~grant_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= CPU_OWN;
         grant_q      <= '0;
         yield_q      <= '0;
         cpu_req_q    <= 1'b0;
         err_q        <= 1'b0;
         hold_cnt_q   <= '0;
         last_owner_q <= IdxW'(NUM_MASTERS - 1);
      end else if (clk_ce) begin
         // The CPU must keep ack high whenever it has handed over the bus, and low otherwise.
         if (((state_q == GRANTED) || (state_q == HANDOFF)) && !bus.cpu_bus_ack) begin
            err_q <= 1'b1;
         end
         if ((state_q == CPU_OWN) && bus.cpu_bus_ack) begin
            err_q <= 1'b1;
         end
         unique case (state_q)
            CPU_OWN: begin
               if (any_req) begin
                  cpu_req_q <= 1'b1;
                  state_q   <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (bus.cpu_bus_ack) begin
                  if (any_req) begin
                     grant_q      <= pick;
                     last_owner_q <= pick_idx;
                     hold_cnt_q   <= '0;
                     state_q      <= GRANTED;
                  end else begin
                     state_q <= HANDOFF;
                  end
               end
            end
            GRANTED: begin
               if (!owner_req) begin
                  grant_q <= '0;
                  yield_q <= '0;
                  state_q <= HANDOFF;
               end else begin
                  if (hold_cnt_q < HoldW'(MAX_HOLD)) begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
                  yield_q <= ((MAX_HOLD != 0) && (hold_cnt_q >= HoldW'(MAX_HOLD)) && others_req)
                             ? grant_q : '0;
               end
            end
            HANDOFF: begin
               if (any_req) begin
                  grant_q      <= pick;
                  last_owner_q <= pick_idx;
                  hold_cnt_q   <= '0;
                  state_q      <= GRANTED;
               end else begin
                  cpu_req_q <= 1'b0;
                  state_q   <= CPU_OWN;
               end
            end
            default: state_q <= CPU_OWN;
         endcase
      end
   end

   // AND-OR mux from the grant register so an ungranted master can never reach the bus.
   always_comb begin
      bus.address_out = '0;
      bus.data_out    = '0;
      bus.write       = 1'b0;
      bus.read        = 1'b0;
      bus.bus_status  = BUS_COMMAND_IDLE;
      case (state_q)
         CPU_OWN, WAIT_ACK: begin
            bus.address_out = bus.cpu_address;
            bus.data_out    = bus.cpu_data;
            bus.write       = bus.cpu_write;
            bus.read        = bus.cpu_read;
            bus.bus_status  = bus.cpu_bus_status;
         end
         GRANTED: begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
               if (grant_q[i]) begin
                  bus.address_out = bus.address_out | bus.m_address[i*24 +: 24];
                  bus.data_out    = bus.data_out | bus.m_data[i*8 +: 8];
                  bus.write       = bus.write | bus.m_write[i];
                  bus.read        = bus.read | bus.m_read[i];
                  bus.bus_status  = bus.bus_status | bus.m_bus_status[i*2 +: 2];
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.grant           = grant_q;
   assign bus.yield           = yield_q;
   assign bus.cpu_bus_request = cpu_req_q;
   assign bus.protocol_error  = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus a random run,
// all cross-checked every cycle against a transaction-level ownership model.
module tb_bus_arbiter;
   import minx_bus_pkg::*;

   localparam int NM = 2;
   localparam int MH = 8;
   localparam int AW = 24 * NM;
   localparam int DW = 8 * NM;
   localparam int SW = 2 * NM;

   localparam int OwnCpu = 0, OwnAsk = 1, OwnMaster = 2, OwnGap = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic clk_ce = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   // Model: who owns the bus and what the arbiter has promised the CPU.
   int           m_mode;
   int           m_owner;
   int           m_last;
   int           m_held;
   bit           m_creq;
   bit           m_err;
   bit [NM-1:0]  m_yield;

   bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

   bus_arbiter #(
      .NUM_MASTERS(NM),
      .MAX_HOLD   (MH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .clk_ce(clk_ce),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic bit bit_of(input logic [NM-1:0] v, input int i);
      return ((32'(v) >> i) & 32'd1) == 32'd1;
   endfunction

   function automatic int rr_winner(input logic [NM-1:0] r, input int last);
      for (int k = 1; k <= NM; k++) begin
         if (bit_of(r, (last + k) % NM)) return (last + k) % NM;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic give_bus(input int w);
      m_mode  = OwnMaster;
      m_owner = w;
      m_last  = w;
      m_held  = 0;
      m_yield = '0;
   endtask

   task automatic model_step();
      logic [NM-1:0] r;
      int w;
      r = bus.req;
      if (!reset) begin
         m_mode = OwnCpu; m_owner = -1; m_last = NM - 1; m_held = 0;
         m_creq = 0; m_err = 0; m_yield = '0;
      end else if (clk_ce) begin
         if ((m_mode == OwnMaster || m_mode == OwnGap) && !bus.cpu_bus_ack) m_err = 1;
         if (m_mode == OwnCpu && bus.cpu_bus_ack) m_err = 1;
         w = rr_winner(r, m_last);
         case (m_mode)
            OwnCpu: if (r != '0) begin m_creq = 1; m_mode = OwnAsk; end
            OwnAsk: if (bus.cpu_bus_ack) begin
               if (w >= 0) give_bus(w);
               else m_mode = OwnGap;
            end
            OwnMaster: begin
               if (!bit_of(r, m_owner)) begin
                  m_mode = OwnGap; m_owner = -1; m_yield = '0;
               end else begin
                  if (MH != 0 && m_held >= MH && (32'(r) & ~(32'd1 << m_owner)) != 0)
                     m_yield = NM'(1 << m_owner);
                  else
                     m_yield = '0;
                  m_held = (m_held + 1 > MH) ? MH : m_held + 1;
               end
            end
            default: begin
               if (w >= 0) give_bus(w);
               else begin m_creq = 0; m_mode = OwnCpu; end
            end
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic check_model();
      logic [NM-1:0] eg;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [23:0]   ea;
      logic [7:0]    ed;
      logic [3:0]    ec;
      a  = bus.m_address;
      d  = bus.m_data;
      s  = bus.m_bus_status;
      eg = (m_mode == OwnMaster) ? NM'(1 << m_owner) : '0;
      ea = '0; ed = '0; ec = {2'b00, BUS_COMMAND_IDLE};
      if (m_mode == OwnCpu || m_mode == OwnAsk) begin
         ea = bus.cpu_address; ed = bus.cpu_data;
         ec = {bus.cpu_write, bus.cpu_read, bus.cpu_bus_status};
      end else if (m_mode == OwnMaster) begin
         ea = 24'(a >> (24 * m_owner));
         ed = 8'(d >> (8 * m_owner));
         ec = {bit_of(bus.m_write, m_owner), bit_of(bus.m_read, m_owner), 2'(s >> (2 * m_owner))};
      end
      chk("model grant", 32'(bus.grant), 32'(eg));
      chk("model yield", 32'(bus.yield), 32'(m_yield));
      chk("model cpu_bus_request", 32'(bus.cpu_bus_request), 32'(m_creq));
      chk("model protocol_error", 32'(bus.protocol_error), 32'(m_err));
      chk("model address_out", 32'(bus.address_out), 32'(ea));
      chk("model data_out", 32'(bus.data_out), 32'(ed));
      chk("model wr/rd/status", 32'({bus.write, bus.read, bus.bus_status}), 32'(ec));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.cpu_bus_ack = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic rand_bus();
      bus.m_address      = AW'({$urandom(), $urandom()});
      bus.m_data         = DW'($urandom());
      bus.m_write        = NM'($urandom());
      bus.m_read         = NM'($urandom());
      bus.m_bus_status   = SW'($urandom());
      bus.cpu_address    = 24'($urandom());
      bus.cpu_data       = 8'($urandom());
      bus.cpu_write      = 1'($urandom());
      bus.cpu_read       = 1'($urandom());
      bus.cpu_bus_status = 2'($urandom());
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NM-1:0] seq [4];
      logic [NM-1:0] rq;
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;

      rand_bus();
      bus.m_address      = {24'h002000, 24'h001000};
      bus.cpu_address    = 24'hABCDEF;
      bus.cpu_bus_status = BUS_COMMAND_MEM_READ;
      bus.req            = '0;
      clk_ce             = 1'b1;
      do_reset();
      chk("reset grant", 32'(bus.grant), 32'h0);
      chk("reset cpu_bus_request", 32'(bus.cpu_bus_request), 32'h0);
      chk("reset protocol_error", 32'(bus.protocol_error), 32'h0);
      chk("reset cpu on bus", 32'(bus.address_out), 32'hABCDEF);

      // Single request
      bus.req = 2'b01;
      step();
      chk("single request raised", 32'(bus.cpu_bus_request), 32'h1);
      step(); step();
      bus.cpu_bus_ack = 1'b1;
      step();
      chk("single grant", 32'(bus.grant), 32'h1);
      chk("single master address", 32'(bus.address_out), 32'h001000);
      bus.req = '0;
      step();
      chk("single handoff grant", 32'(bus.grant), 32'h0);
      chk("single handoff idle", 32'(bus.bus_status), 32'(BUS_COMMAND_IDLE));
      chk("single handoff address", 32'(bus.address_out), 32'h0);
      step();
      chk("single request dropped", 32'(bus.cpu_bus_request), 32'h0);
      chk("single cpu back", 32'(bus.address_out), 32'hABCDEF);
      bus.cpu_bus_ack = 1'b0;

      // Round-robin between two busy masters
      do_reset();
      bus.req = 2'b11;
      step();
      bus.cpu_bus_ack = 1'b1;
      step();
      chk("rr first grant", 32'(bus.grant), 32'(seq[0]));
      for (int n = 1; n < 4; n++) begin
         step(); step(); step();
         bus.req = 2'b11 & ~bus.grant;
         step();
         chk("rr idle between", 32'(bus.grant), 32'h0);
         chk("rr cpu not re-entered", 32'(bus.cpu_bus_request), 32'h1);
         bus.req = 2'b11;
         step();
         chk("rr grant order", 32'(bus.grant), 32'(seq[n]));
      end
      bus.req = '0;
      step(); step();
      bus.cpu_bus_ack = 1'b0;

      // Yield after MAX_HOLD
      do_reset();
      bus.req = 2'b01;
      step();
      bus.cpu_bus_ack = 1'b1;
      step();
      step(); step();
      bus.req = 2'b11;
      for (int n = 0; n < 6; n++) step();
      chk("yield not yet", 32'(bus.yield), 32'h0);
      step();
      chk("yield raised", 32'(bus.yield), 32'h1);
      chk("yield grant kept", 32'(bus.grant), 32'h1);
      bus.req = 2'b10;
      step();
      chk("yield handoff", 32'(bus.grant), 32'h0);
      chk("yield cleared", 32'(bus.yield), 32'h0);
      step();
      chk("yield next owner", 32'(bus.grant), 32'h2);
      bus.req = '0;
      step(); step();
      bus.cpu_bus_ack = 1'b0;

      // Withdrawn request
      do_reset();
      bus.req = 2'b10;
      step();
      bus.req = '0;
      for (int n = 0; n < 4; n++) step();
      chk("withdrawn still asking", 32'(bus.cpu_bus_request), 32'h1);
      bus.cpu_bus_ack = 1'b1;
      step();
      chk("withdrawn no grant", 32'(bus.grant), 32'h0);
      chk("withdrawn handoff idle", 32'(bus.address_out), 32'h0);
      step();
      chk("withdrawn request falls", 32'(bus.cpu_bus_request), 32'h0);
      bus.cpu_bus_ack = 1'b0;
      step();
      chk("withdrawn no error", 32'(bus.protocol_error), 32'h0);

      // Reset mid-grant while clk_ce is low
      do_reset();
      bus.req = 2'b01;
      step();
      bus.cpu_bus_ack = 1'b1;
      step();
      clk_ce = 1'b0;
      reset  = 1'b0;
      step();
      chk("midreset grant", 32'(bus.grant), 32'h0);
      chk("midreset cpu_bus_request", 32'(bus.cpu_bus_request), 32'h0);
      reset = 1'b1; clk_ce = 1'b1; bus.cpu_bus_ack = 1'b0;
      bus.req = 2'b11;
      step();
      bus.cpu_bus_ack = 1'b1;
      step();
      chk("midreset master 0 first", 32'(bus.grant), 32'h1);
      bus.req = '0;
      step(); step();
      bus.cpu_bus_ack = 1'b0;

      // Random traffic with a well-behaved CPU
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rand_bus();
         clk_ce = ($urandom_range(0, 3) != 0);
         rq = bus.req;
         for (int i = 0; i < NM; i++) if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
         bus.req = rq;
         if (!bus.cpu_bus_request) bus.cpu_bus_ack = 1'b0;
         else if ($urandom_range(0, 2) == 0) bus.cpu_bus_ack = 1'b1;
         reset = ($urandom_range(0, 299) != 0);
         step();
      end
      reset = 1'b1;
      clk_ce = 1'b1;

      // Protocol error is sticky until reset
      do_reset();
      bus.req = 2'b01;
      step();
      bus.cpu_bus_ack = 1'b1;
      step();
      bus.cpu_bus_ack = 1'b0;
      step();
      chk("perr flagged", 32'(bus.protocol_error), 32'h1);
      chk("perr grant held", 32'(bus.grant), 32'h1);
      bus.cpu_bus_ack = 1'b1;
      bus.req = '0;
      step(); step();
      bus.cpu_bus_ack = 1'b0;
      step();
      chk("perr sticky", 32'(bus.protocol_error), 32'h1);
      do_reset();
      chk("perr cleared by reset", 32'(bus.protocol_error), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the single external MINX bus (address/data/read/write/status) between the s1c88 CPU and NUM_MASTERS secondary bus masters (PRC, future DMA/IR engines). The CPU is the default owner. A secondary master gains the bus only after the arbiter raises bus_request to the CPU and the CPU answers with bus_ack. Between secondary masters, the arbiter grants round-robin, optionally asks a long-holding owner to yield, and drives the muxed bus toward memory and the register decoders.

Parameters:
NUM_MASTERS, 2, number of secondary requesters (1..8)
MAX_HOLD, 0, clk_ce cycles an owner may hold the bus before yield is raised while others wait; 0 = never yield

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
clk_ce  in  1  clock enable; all state advances only when high (reset excepted)
req  in  NUM_MASTERS  per-master bus request, level
grant  out  NUM_MASTERS  one-hot grant, registered
yield  out  NUM_MASTERS  request to the owner to release at its next safe boundary
m_address  in  NUM_MASTERS*24  packed master addresses
m_data  in  NUM_MASTERS*8  packed master write data
m_write  in  NUM_MASTERS  master write strobes
m_read  in  NUM_MASTERS  master read strobes
m_bus_status  in  NUM_MASTERS*2  master bus status
cpu_address  in  24  CPU address
cpu_data  in  8  CPU write data
cpu_write  in  1  CPU write
cpu_read  in  1  CPU read
cpu_bus_status  in  2  CPU bus status
cpu_bus_ack  in  1  CPU has released the bus
cpu_bus_request  out  1  request for the CPU to release the bus
address_out  out  24  muxed bus address
data_out  out  8  muxed bus write data
write  out  1  muxed write
read  out  1  muxed read
bus_status  out  2  muxed status
protocol_error  out  1  sticky; cleared only by reset

Behaviour:
- Reset (reset==0 at posedge clk, regardless of clk_ce):
  - State goes to CPU_OWN.
  - grant=0, yield=0, cpu_bus_request=0, protocol_error=0, hold_cnt=0, last_owner=NUM_MASTERS-1.
  - Reset mid-grant drops the grant on that same edge.
- States and outputs:
  - CPU_OWN: bus mux selects CPU. If |req, set cpu_bus_request=1 and go to WAIT_ACK.
  - WAIT_ACK: bus mux still selects CPU and cpu_bus_request stays 1, even if req drops. On cpu_bus_ack=1:
    - If |req, grant the round-robin winner and go to GRANTED.
    - Otherwise go to HANDOFF.
  - GRANTED(i): bus mux selects master i combinationally from the grant register.
    - hold_cnt increments each clk_ce cycle and saturates at MAX_HOLD.
    - If req[i]==0, clear grant and yield and go to HANDOFF.
  - HANDOFF: one turnaround cycle. The bus is idle: read=0, write=0, address=0, data=0, bus_status=BUS_COMMAND_IDLE.
    - If |req, grant the winner and go to GRANTED; cpu_bus_request stays 1 and the CPU is not re-entered.
    - Otherwise clear cpu_bus_request and go to CPU_OWN.
- Latency:
  - req rise to cpu_bus_request is 1 clk_ce cycle.
  - cpu_bus_ack to grant is 1 cycle.
  - Grant release to the next grant is 2 cycles (GRANTED→HANDOFF→GRANTED).
- Round-robin:
  - Search starts at (last_owner+1) mod NUM_MASTERS; the first set req bit wins.
  - last_owner updates on every grant.
  - After reset, master 0 has highest priority.
- Yield:
  - Applies only when MAX_HOLD!=0.
  - In GRANTED(i), if hold_cnt>=MAX_HOLD and any req[j] (j!=i) is set, yield[i]=1 from the next cycle.
  - The arbiter never revokes a grant; yield is advisory.
  - yield clears when the requests from other masters drop or the grant ends.
  - hold_cnt resets to 0 on each new grant.
- Protocol errors (set protocol_error; state unchanged):
  - cpu_bus_ack=0 while in GRANTED or HANDOFF.
  - cpu_bus_ack=1 while in CPU_OWN.
- Simultaneous events:
  - req[i] falling while another req rises in the same cycle: the arbiter passes through HANDOFF; it never hands the grant directly between masters.
  - A new req arriving during HANDOFF is seen in that cycle.
- grant is always one-hot or zero. The mux never selects a master whose grant bit is clear.

Decomposition:
- Shared package minx_bus_pkg:
  - BUS_COMMAND_* status constants, including BUS_COMMAND_IDLE.
  - arb_state_t enum: CPU_OWN, WAIT_ACK, GRANTED, HANDOFF.
- One combinational sub-module, rr_pick: inputs req and last_owner; outputs a one-hot winner and its index. Instantiated once.

Test Plan:
- Single request: NUM_MASTERS=2, req[0]=1 → cpu_bus_request=1 next ce cycle. Ack 3 cycles later → grant=2'b01 one cycle after ack; bus shows m_address[0]=24'h001000. Drop req → 1 HANDOFF cycle with bus_status idle, then cpu_bus_request=0 and the CPU address is back on the bus.
- Round-robin: req=2'b11 held, each owner drops and re-raises its req after 4 cycles → grant sequence 01,10,01,10, with exactly one idle cycle between grants and no return to CPU_OWN.
- Yield: MAX_HOLD=8, master 0 holds and req[1] rises at cycle 2 of the grant → yield[0]=1 on the cycle after hold_cnt reaches 8. Master 0 drops → grant=2'b10 two cycles later.
- Withdrawn request: req[1] pulses for 1 cycle, ack arrives 5 cycles later → WAIT_ACK then HANDOFF, no grant, cpu_bus_request falls on the HANDOFF exit.
- Reset mid-grant: reset=0 for one edge while clk_ce=0 in GRANTED → grant=0, cpu_bus_request=0, state CPU_OWN. After release, master 0 wins first.
- Protocol error: in GRANTED, force cpu_bus_ack=0 → protocol_error=1 and the grant is held. The flag stays set after the sequence ends until reset.
